// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline-register definitions for the three-stage core: elastic stage
// state encoding and payload layouts used to build NOP bubbles.
package riscv_pipe_pkg;

  // Encoding equals the number of entries held, so it doubles as occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // IF->EXE bundle: {pc, instr}
  localparam int IFEX_INSTR_LSB = 0;
  localparam int IFEX_PC_LSB    = 32;
  localparam int IFEX_W         = 64;

  // EXE->MWB bundle: {ctrl, pc, instr}
  localparam int EXMWB_INSTR_LSB = 0;
  localparam int EXMWB_PC_LSB    = 32;
  localparam int EXMWB_CTRL_LSB  = 64;
  localparam int EXMWB_W         = 96;

  localparam logic [IFEX_W-1:0]  IFEX_BUBBLE  = {32'h0, NOP_INSTR};
  localparam logic [EXMWB_W-1:0] EXMWB_BUBBLE = {32'h0, 32'h0, NOP_INSTR};

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter; clr wins over inc, sticks at all-ones.
// One-cycle update latency, no backpressure.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic two-entry pipeline register: 1-cycle latency, full throughput; in_ready
// is registered (skid entry absorbs the cycle downstream stalls), flush inserts a bubble.
module pipe_stage_reg
  import riscv_pipe_pkg::*;
#(
  parameter int                   PAYLOAD_W    = 96,
  parameter logic [PAYLOAD_W-1:0] BUBBLE_VALUE = '0,
  parameter int                   CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  input  logic                 out_ready,
  input  logic                 flush,
  input  logic                 cnt_clr,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  state_e               r_state, w_state_nxt;
  logic [PAYLOAD_W-1:0] r_main, w_main_nxt;
  logic [PAYLOAD_W-1:0] r_skid, w_skid_nxt;
  logic                 w_in_fire, w_out_fire;

  assign in_ready    = (r_state != ST_TWO);
  assign out_valid   = (r_state != ST_EMPTY);
  // r_main is reloaded with the bubble on every path into EMPTY.
  assign out_payload = r_main;
  assign occupancy   = r_state;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = BUBBLE_VALUE;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = in_payload;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_payload;
          end else if (w_in_fire) begin
            w_state_nxt = ST_TWO;
            w_skid_nxt  = in_payload;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = BUBBLE_VALUE;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = BUBBLE_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_main  <= BUBBLE_VALUE;
      r_skid  <= BUBBLE_VALUE;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (out_valid & ~out_ready),
    .count(stall_cnt)
  );

endmodule
